// File: rtl/mem_port_arbiter_pkg.sv
// Purpose: shared types and default widths for the unified-memory port arbiter.
// Latency: n/a (types only).
// Backpressure: n/a.
package mips_pkg;

  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_MAX_WAIT   = 15;

  // Arbiter sequencing states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    FETCH = 2'd2,
    ERR   = 2'd3
  } arb_state_t;

  // Which requester owned the most recent grant; drives round-robin on contention.
  typedef enum logic {
    GRANT_FETCH = 1'b0,
    GRANT_DATA  = 1'b1
  } grant_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Purpose: bundles the fetch, load/store and memory-side signals of the arbiter.
// Latency: n/a (wiring only).
// Backpressure: requesters hold their request until the matching done pulse.
// Ports: master = arbiter view (drives done/rdata/stall/mem_*), slave = pipeline + memory view.
interface mem_port_arbiter_if
  import mips_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);

  // Fetch path
  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic [DATA_WIDTH-1:0] if_rdata;
  logic                  if_done;

  // Load/store path
  logic                  d_read;
  logic                  d_write;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [DATA_WIDTH-1:0] d_wdata;
  logic [DATA_WIDTH-1:0] d_rdata;
  logic                  d_done;

  // Pipeline freeze
  logic                  stall;

  // Memory side
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_ack;

  logic                  timeout_err;

  modport master (
    input  if_req, if_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_ack,
    output if_rdata, if_done, d_rdata, d_done, stall,
           mem_req, mem_we, mem_addr, mem_wdata, timeout_err
  );

  modport slave (
    output if_req, if_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_ack,
    input  if_rdata, if_done, d_rdata, d_done, stall,
           mem_req, mem_we, mem_addr, mem_wdata, timeout_err
  );

endinterface

// File: rtl/mem_port_arbiter_wait_timer.sv
// Purpose: counts cycles an access has waited for its acknowledge.
// Latency: o_expired is combinational on the registered count.
// Backpressure: none; counts only while i_enable is high, saturates at the limit.
// Ports: clk/reset, i_clear (restart count), i_enable (waiting cycle), o_expired (last allowed cycle).
module wait_timer #(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int            CW   = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] LAST = CW'(MAX_WAIT - 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != LAST)) begin
      r_count <= r_count + 1'b1;
    end
  end

  // The count holds the cycles already waited, so reaching LAST while still
  // waiting means this is the MAX_WAIT-th cycle: no ack now means the limit is hit.
  assign o_expired = i_enable && (r_count == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Purpose: shares one memory port between instruction fetch and load/store, with timeout trap.
// Latency: 2 cycles minimum from request to done (grant register + ack register).
// Backpressure: stall holds the pipeline while any access is pending; ERR stalls until reset.
// Ports: clk, reset (async active-high), bus (mem_port_arbiter_if.master: fetch, data, memory, error).
module mem_port_arbiter
  import mips_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MAX_WAIT   = DEF_MAX_WAIT
) (
  input logic                clk,
  input logic                reset,
  mem_port_arbiter_if.master bus
);

  arb_state_t            r_state;
  grant_t                r_last_grant;
  logic                  r_mem_req;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic [DATA_WIDTH-1:0] r_if_rdata;
  logic [DATA_WIDTH-1:0] r_d_rdata;
  logic                  r_if_done;
  logic                  r_d_done;
  logic                  r_timeout_err;

  logic w_d_req;
  logic w_f_req;
  logic w_grant_any;
  logic w_grant_data;
  logic w_busy;
  logic w_expired;

  // A requester keeps its request up during its own done cycle; masking it
  // there stops the finished access from being granted a second time.
  assign w_d_req = (bus.d_read | bus.d_write) & ~r_d_done;
  assign w_f_req = bus.if_req & ~r_if_done;

  assign w_grant_any  = w_d_req | w_f_req;
  // On contention, data wins unless it also had the previous grant.
  assign w_grant_data = w_d_req & (~w_f_req | (r_last_grant == GRANT_FETCH));

  assign w_busy = (r_state == DATA) || (r_state == FETCH);

  wait_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_timer (
    .clk       (clk),
    .reset     (reset),
    .i_clear   ((r_state == IDLE) && w_grant_any),
    .i_enable  (w_busy && !bus.mem_ack),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_last_grant  <= GRANT_FETCH;
      r_mem_req     <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
      r_if_rdata    <= '0;
      r_d_rdata     <= '0;
      r_if_done     <= 1'b0;
      r_d_done      <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_if_done <= 1'b0;
      r_d_done  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant_any) begin
            r_mem_req <= 1'b1;
            if (w_grant_data) begin
              r_mem_addr   <= bus.d_addr;
              r_mem_wdata  <= bus.d_wdata;
              // A simultaneous read and write is treated as a write.
              r_mem_we     <= bus.d_write;
              r_last_grant <= GRANT_DATA;
              r_state      <= DATA;
            end else begin
              r_mem_addr   <= bus.if_addr;
              r_mem_we     <= 1'b0;
              r_last_grant <= GRANT_FETCH;
              r_state      <= FETCH;
            end
          end
        end
        DATA, FETCH: begin
          // Ack is checked before expiry so a last-cycle ack still completes.
          if (bus.mem_ack) begin
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            if (r_state == DATA) begin
              if (!r_mem_we) begin
                r_d_rdata <= bus.mem_rdata;
              end
              r_d_done <= 1'b1;
            end else begin
              r_if_rdata <= bus.mem_rdata;
              r_if_done  <= 1'b1;
            end
            r_state <= IDLE;
          end else if (w_expired) begin
            r_mem_req     <= 1'b0;
            r_mem_we      <= 1'b0;
            r_timeout_err <= 1'b1;
            r_state       <= ERR;
          end
        end
        default: begin
          // ERR: absorbing until reset; acks are ignored.
        end
      endcase
    end
  end

  assign bus.stall       = !reset && ((r_state != IDLE) || w_d_req || w_f_req);
  assign bus.mem_req     = r_mem_req;
  assign bus.mem_we      = r_mem_we;
  assign bus.mem_addr    = r_mem_addr;
  assign bus.mem_wdata   = r_mem_wdata;
  assign bus.if_rdata    = r_if_rdata;
  assign bus.if_done     = r_if_done;
  assign bus.d_rdata     = r_d_rdata;
  assign bus.d_done      = r_d_done;
  assign bus.timeout_err = r_timeout_err;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-port unified memory between the instruction-fetch path and the load/store path driven by the decoder's `mem_read`/`mem_write`. Sequences each access as a registered request/acknowledge transaction with variable memory latency and raises `stall` to freeze the PC and pipeline registers while any access is pending. A wait timer traps a memory that never acknowledges.

## Interface
- `ADDR_WIDTH`, 32: address width.
- `DATA_WIDTH`, 32: data width.
- `MAX_WAIT`, 15: maximum number of cycles `mem_req` may wait for `mem_ack`. Must be ≥ 1.

- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `if_req`  in  1  fetch request; held high until `if_done`.
- `if_addr`  in  ADDR_WIDTH  fetch address.
- `if_rdata`  out  DATA_WIDTH  fetched word; valid while `if_done` is high.
- `if_done`  out  1  one-cycle completion pulse for fetch.
- `d_read`, `d_write`  in  1 each  load/store request; held until `d_done`.
- `d_addr`  in  ADDR_WIDTH  load/store address.
- `d_wdata`  in  DATA_WIDTH  store data.
- `d_rdata`  out  DATA_WIDTH  load data; valid while `d_done` is high.
- `d_done`  out  1  one-cycle completion pulse for load/store.
- `stall`  out  1  freezes the pipeline.
- `mem_req`, `mem_we`  out  1 each  memory request and write enable.
- `mem_addr`  out  ADDR_WIDTH  memory address.
- `mem_wdata`  out  DATA_WIDTH  memory write data.
- `mem_rdata`  in  DATA_WIDTH  memory read data; valid with `mem_ack`.
- `mem_ack`  in  1  memory acknowledge; single cycle.
- `timeout_err`  out  1  sticky error flag.

## Operation
- **States:**
  - `IDLE`: no access in flight.
  - `DATA`: load/store access in flight.
  - `FETCH`: instruction fetch in flight.
  - `ERR`: memory failed to acknowledge.
- **Reset values:** state `IDLE`. All of `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `if_done`, `d_done`, `if_rdata`, `d_rdata` and `timeout_err` are 0. `last_grant` is FETCH, so data wins the first contention.
- **Requests in `IDLE`:**
  - Data request: `d_read | d_write`.
  - Fetch request: `if_req`.
  - The requester whose done pulse is high this cycle is masked for this cycle.
- **Grant in `IDLE`:**
  - One unmasked request: grant it.
  - Both unmasked: grant the one opposite `last_grant` (alternating, no starvation).
  - On grant, register `mem_req=1`, address and data, `mem_we` (= `d_write` for data, 0 for fetch), and `last_grant`, then move to `DATA` or `FETCH`.
- If `d_read` and `d_write` are both high, the access is a write and the read is ignored.
- **In `DATA`/`FETCH`:**
  - Hold the `mem_*` outputs stable.
  - On sampled `mem_ack`: clear `mem_req`/`mem_we`, register `mem_rdata` into the matching `*_rdata` (writes leave `d_rdata` unchanged), pulse the matching `*_done`, and return to `IDLE`.
- **Wait counter:**
  - Clears on grant and increments each cycle in `DATA`/`FETCH` without ack.
  - When it reaches `MAX_WAIT` with no ack: clear `mem_req`, set `timeout_err`, and go to `ERR`.
  - An ack in the same cycle the count reaches `MAX_WAIT` wins: the access completes and no error is raised.
- **`ERR`:** absorbing until `reset`. `mem_req`=0, no done pulses, and `mem_ack` is ignored.
- **`stall`** is combinational:
  - 1 in `DATA`, `FETCH` and `ERR`.
  - In `IDLE`, 1 when any unmasked request is present.
  - 0 while `reset` is high.
- Requesters drop or change their request in the cycle after their done pulse.
- **Reset mid-access:** `mem_req` drops immediately (asynchronously), and no done pulse is issued for the aborted access.

## Timing
- Request present in `IDLE` at cycle N: `mem_req` is high from cycle N+1.
- `mem_ack` in cycle N+k (k ≥ 1): `*_done` and `*_rdata` are valid in cycle N+k+1 with the state back in `IDLE`.
- Minimum latency: 2 cycles from request to done.
- Back-to-back alternating requesters: one access every 2 cycles. The same requester repeating: every 3 cycles.
- `mem_ack` is sampled only when `mem_req` was high in the preceding registered state. A spurious ack in `IDLE` is ignored.

## Structure
- The shared package `mips_pkg` holds:
  - `arb_state_t` enum (`IDLE`, `DATA`, `FETCH`, `ERR`).
  - `grant_t` enum (`GRANT_FETCH`, `GRANT_DATA`).
  - Default widths.
- One sub-module, `wait_timer`: a counter with `clear`/`enable` inputs and an `expired` output, parameterised by `MAX_WAIT`.
- Everything else (FSM, output registers, mask logic) lives in `mem_port_arbiter`.

## Test plan
- **Fetch only:** `if_req=1`, `if_addr=0x0000_0040`, memory acks one cycle after `mem_req` with `0x2008_0005` → `mem_req` high in cycle 1, `if_done` in cycle 2 with `if_rdata=0x2008_0005`, and `stall`=1 in cycles 0–1 and 0 in cycle 2.
- **Contention after reset:** `if_req` and `d_write` (addr `0x100`, data `0xDEAD_BEEF`) both high → data is granted first with `mem_we=1`, fetch is granted in the cycle of `d_done`, and `if_done` comes 2 cycles later.
- **Both read and write:** `d_read` and `d_write` both high → `mem_we=1`, `d_done` pulses, and `d_rdata` is unchanged.
- **Wait-state memory:** ack delayed 4 cycles → `mem_addr` is stable throughout, `stall` is held, and exactly one `d_done` pulse is issued.
- **Timeout:** `MAX_WAIT=3`, no ack → `ERR` entered 3 cycles after grant, `timeout_err`=1, `mem_req`=0, `stall`=1; a late ack is ignored.
- **Reset mid-access:** `reset` asserted while in `FETCH` → `mem_req` falls before the next edge, all outputs are zero, and there is no `if_done` after reset is released.
